// File: rtl/register_file.sv
// 16 x DATA_W register file with three combinational read ports,
// one writeback port with write-through bypass, and a PC shadow load into R15.
module register_file #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              LE,
  input  logic [3:0]        RW,
  input  logic [DATA_W-1:0] PW,
  input  logic              PC_LE,
  input  logic [PC_W-1:0]   PC_in,
  input  logic [3:0]        RA,
  input  logic [3:0]        RB,
  input  logic [3:0]        RD,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PD
);

  localparam int NREG = 16;
  localparam int PC_IDX = 15;

  logic [DATA_W-1:0] regs [NREG];

  // Write-through read: a pending writeback to the selected register is
  // forwarded in the same cycle, unless reset is being applied. The PC
  // shadow load is deliberately not forwarded.
  function automatic logic [DATA_W-1:0] bypass_read(
    input logic [3:0]        sel,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic              clr,
    input logic [3:0]        wr_idx,
    input logic [DATA_W-1:0] wr_data
  );
    if (wr_en && !clr && (sel == wr_idx)) return wr_data;
    return stored;
  endfunction

  // Register update: reset clears everything; otherwise the PC load is
  // applied first so that a writeback to R15 on the same edge overrides it.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (PC_LE) regs[PC_IDX] <= {{(DATA_W-PC_W){1'b0}}, PC_in};
      if (LE)    regs[RW]     <= PW;
    end
  end

  // Combinational read ports with independent per-port bypass.
  always_comb begin
    PA = bypass_read(RA, regs[RA], LE, Clr, RW, PW);
    PB = bypass_read(RB, regs[RB], LE, Clr, RW, PW);
    PD = bypass_read(RD, regs[RD], LE, Clr, RW, PW);
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read-port
// values computed from an array model; a monitor compares on each negedge.
module tb_register_file;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        LE;
  logic [3:0]  RW;
  logic [31:0] PW;
  logic        PC_LE;
  logic [7:0]  PC_in;
  logic [3:0]  RA, RB, RD;
  logic [31:0] PA, PB, PD;

  register_file dut (
    .Clk(Clk), .Clr(Clr), .LE(LE), .RW(RW), .PW(PW),
    .PC_LE(PC_LE), .PC_in(PC_in),
    .RA(RA), .RB(RB), .RD(RD),
    .PA(PA), .PB(PB), .PD(PD)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pa, pb, pd;
    logic [3:0]  ra, rb, rd;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [16];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  function automatic logic [31:0] model_read(input logic [3:0] sel, input logic le,
                                             input logic clr, input logic [3:0] rw,
                                             input logic [31:0] pw);
    if (le && !clr && sel == rw) return pw;
    return model[sel];
  endfunction

  // One cycle of stimulus: drive inputs, predict reads, let the edge happen,
  // then advance the model by what the edge should have done.
  task automatic apply(input string tag, input logic clr, input logic le,
                       input logic [3:0] rw, input logic [31:0] pw,
                       input logic pcle, input logic [7:0] pcin,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
    exp_t e;
    Clr = clr; LE = le; RW = rw; PW = pw; PC_LE = pcle; PC_in = pcin;
    RA = ra; RB = rb; RD = rd;
    e.pa = model_read(ra, le, clr, rw, pw);
    e.pb = model_read(rb, le, clr, rw, pw);
    e.pd = model_read(rd, le, clr, rw, pw);
    e.ra = ra; e.rb = rb; e.rd = rd;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge Clk);
    if (clr) begin
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
    end else begin
      if (pcle) model[15] = {24'h0, pcin};
      if (le)   model[rw] = pw;
    end
    #1;
  endtask

  task automatic idle_read(input string tag, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [3:0] rd);
    apply(tag, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 8'h0, ra, rb, rd);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++)
      idle_read(tag, 4'(i), 4'(15 - i), 4'((i + 5) % 16));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: read ports are valid mid-cycle; pop one expectation per cycle.
  initial begin
    forever begin
      @(negedge Clk);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("%s PA[R%0d]", e.tag, e.ra), PA, e.pa);
        check($sformatf("%s PB[R%0d]", e.tag, e.rb), PB, e.pb);
        check($sformatf("%s PD[R%0d]", e.tag, e.rd), PD, e.pd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] r;
    Clr = 1'b1; LE = 1'b0; RW = '0; PW = '0; PC_LE = 1'b0; PC_in = '0;
    RA = '0; RB = '0; RD = '0;
    // Initial reset without expectations (contents undefined beforehand).
    @(posedge Clk);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    #1;

    sweep("reset_zero");

    // Write then read, neighbours untouched.
    apply("wr_r3", 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 8'h0, 4'd3, 4'd2, 4'd4);
    idle_read("rd_r3", 4'd3, 4'd2, 4'd4);

    // Same-cycle bypass on all three ports.
    apply("wr_r5", 1'b0, 1'b1, 4'd5, 32'h11111111, 1'b0, 8'h0, 4'd5, 4'd0, 4'd3);
    apply("byp_r5", 1'b0, 1'b1, 4'd5, 32'h22222222, 1'b0, 8'h0, 4'd5, 4'd5, 4'd5);
    idle_read("rd_r5", 4'd5, 4'd5, 4'd5);

    // R15: PC load not bypassed, then writeback wins over PC load.
    apply("pc_2c", 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 8'h2C, 4'd15, 4'd15, 4'd0);
    idle_read("rd_pc", 4'd15, 4'd3, 4'd5);
    apply("r15_conf", 1'b0, 1'b1, 4'd15, 32'h00000080, 1'b1, 8'h30, 4'd15, 4'd14, 4'd15);
    idle_read("rd_r15", 4'd15, 4'd15, 4'd15);

    // Reset mid-operation: no bypass while Clr is high, then all zero.
    apply("wr_r7", 1'b0, 1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 8'h0, 4'd0, 4'd0, 4'd0);
    apply("clr_byp", 1'b1, 1'b1, 4'd7, 32'h5, 1'b1, 8'h77, 4'd7, 4'd7, 4'd15);
    sweep("post_clr");

    // First edge after reset writes normally.
    apply("wr_first", 1'b0, 1'b1, 4'd9, 32'hCAFEF00D, 1'b0, 8'h0, 4'd9, 4'd1, 4'd9);
    idle_read("rd_r9", 4'd9, 4'd9, 4'd8);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 300; n++) begin
      r = 4'($urandom_range(0, 15));
      apply("rand", ($urandom_range(0, 49) == 0), 1'($urandom), r, $urandom,
            ($urandom_range(0, 3) == 0), 8'($urandom),
            ($urandom_range(0, 2) == 0) ? r : 4'($urandom),
            4'($urandom), ($urandom_range(0, 3) == 0) ? r : 4'($urandom));
    end

    // Hold: nothing enabled while RW/PW toggle, then every register is intact.
    for (int n = 0; n < 10; n++)
      apply("hold", 1'b0, 1'b0, 4'($urandom), $urandom, 1'b0, 8'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom));
    sweep("hold_chk");

    // Drain the scoreboard.
    repeat (3) @(negedge Clk);
    #1;
    total_cnt++;
    if (sb_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have exactly one clock, Clk; reset Clr SHALL be synchronous and active-high.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Clr  input  1  synchronous active-high reset, sampled on posedge Clk.
REQ-004 LE  input  1  writeback enable, driven from the MEM/WB RF-enable output.
REQ-005 RW  input  4  writeback destination register index.
REQ-006 PW  input  32  writeback data.
REQ-007 PC_LE  input  1  program-counter shadow load enable for R15.
REQ-008 PC_in  input  8  current PC value, zero-extended into R15.
REQ-009 RA, RB, RD  input  4 each  read-port select indices for the ID stage.
REQ-010 PA, PB, PD  output  32 each  read-port data for RA, RB and RD respectively.

Function
REQ-011 The block SHALL hold 16 registers, R0-R15, each 32 bits wide.
REQ-012 On posedge Clk with Clr=0, LE=1 and RW in 0-14, R[RW] SHALL take PW; all other registers SHALL hold their value.
REQ-013 On posedge Clk with Clr=0 and PC_LE=1, R15 SHALL take {24'b0, PC_in}.
REQ-014 If LE=1, RW=15 and PC_LE=1 on the same edge, the writeback SHALL win, so R15 takes PW.
REQ-015 If LE=1, RW=15 and PC_LE=0, R15 SHALL take PW.
REQ-016 If LE=0 and PC_LE=0, no register SHALL change.
REQ-017 Read ports SHALL be combinational with zero-cycle latency: PA=R[RA], PB=R[RB], PD=R[RD].
REQ-018 Write-through bypass: while LE=1 and Clr=0, any port whose select equals RW SHALL output PW in the same cycle, before the edge.
REQ-019 The bypass SHALL apply independently to each port, so two or three ports may bypass simultaneously.
REQ-020 The bypass SHALL apply to RW=15.
REQ-021 There SHALL be no bypass for PC_LE; R15 reads SHALL return the stored R15 until the edge.
REQ-022 While Clr=1, the bypass SHALL be disabled and the read ports SHALL show stored values.
REQ-023 Reads SHALL never alter state, and an unwritten register SHALL read 0 after reset.

Reset
REQ-024 On posedge Clk with Clr=1, all 16 registers SHALL become 32'h00000000.
REQ-025 Clr SHALL have priority over LE and PC_LE on the same edge.
REQ-026 Assertion of Clr between edges SHALL have no effect until the next posedge; the block is not asynchronously cleared.
REQ-027 After Clr deasserts, the first edge with LE or PC_LE set SHALL write normally; no recovery cycles SHALL be required.
REQ-028 Before the first Clr edge, register contents are undefined; the bench SHALL apply Clr for at least 1 cycle first.

Verification
REQ-029 Clr=1 for 1 edge -> PA, PB and PD read 0 for every RA, RB and RD in 0-15.
REQ-030 Write then read:
- Stimulus: LE=1, RW=3, PW=32'hDEADBEEF, edge; then LE=0, RA=3.
- Response: PA=32'hDEADBEEF; R2 and R4 still read 0.
REQ-031 Same-cycle bypass:
- Stimulus: R5=32'h11111111; set LE=1, RW=5, PW=32'h22222222, RA=RB=RD=5 before the edge.
- Response: PA=PB=PD=32'h22222222 combinationally, and R5=32'h22222222 after the edge.
REQ-032 R15 conflict:
- Stimulus: PC_LE=1, PC_in=8'h2C, LE=0, edge -> R15 reads 32'h0000002C.
- Stimulus: then PC_LE=1, PC_in=8'h30, LE=1, RW=15, PW=32'h00000080, edge.
- Response: R15 reads 32'h00000080.
REQ-033 Reset mid-operation:
- Stimulus: R7=32'hA5A5A5A5; set Clr=1, LE=1, RW=7, PW=32'h5, RA=7.
- Response: PA=32'hA5A5A5A5 before the edge, with no bypass; after the edge R7=0 and every register reads 0.
REQ-034 Hold:
- Stimulus: LE=0, PC_LE=0 for 10 edges with PW and RW toggling randomly.
- Response: all 16 registers are unchanged.
